// File: rtl/vpu_writeback_if.sv
// UB write port: one complete deskewed row per valid/ready handshake.
interface vpu_writeback_if #(
  parameter int N      = 2,
  parameter int ADDR_W = 16
);
  logic              ub_wr_valid;
  logic              ub_wr_ready;
  logic [ADDR_W-1:0] ub_wr_addr;
  logic [N*16-1:0]   ub_wr_data;

  modport master (output ub_wr_valid, ub_wr_addr, ub_wr_data, input ub_wr_ready);
  modport slave  (input ub_wr_valid, ub_wr_addr, ub_wr_data, output ub_wr_ready);
endinterface

// File: rtl/vpu_writeback.sv
// Deskews column-staggered VPU lane outputs through per-lane FIFOs and writes
// complete rows to the unified buffer at consecutive addresses.
module vpu_writeback #(
  parameter int N      = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [N*16-1:0]   vpu_data_in,
  input  logic [N-1:0]      vpu_valid_in,
  vpu_writeback_if.master   ub,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q, rows_q, rows_written;
  logic [ADDR_W-1:0] accept_cnt [N];
  logic [15:0]       mem        [N][DEPTH];
  logic [PW-1:0]     wr_ptr     [N];
  logic [PW-1:0]     rd_ptr     [N];
  logic [PW:0]       count      [N];
  logic [N-1:0]      nonempty, full, want, push;
  logic              fire, launch, last_row, ovf_set;

  always_comb begin
    nonempty = '0;
    full     = '0;
    want     = '0;
    push     = '0;
    ovf_set  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      nonempty[j] = (count[j] != '0);
      full[j]     = (count[j] == (PW+1)'(DEPTH));
      want[j]     = (state == RUN) && vpu_valid_in[j] && (accept_cnt[j] < rows_q);
      // A full FIFO still accepts when it is popped on the same edge.
      push[j]     = want[j] && (!full[j] || fire);
      if (want[j] && !push[j]) ovf_set = 1'b1;
    end
  end

  always_comb begin
    ub.ub_wr_data = '0;
    for (int unsigned j = 0; j < N; j++)
      ub.ub_wr_data[16*j +: 16] = mem[j][rd_ptr[j]];
  end

  assign ub.ub_wr_valid = (state == RUN) && (&nonempty);
  assign ub.ub_wr_addr  = base_q + rows_written;
  assign fire           = ub.ub_wr_valid && ub.ub_wr_ready;
  assign launch         = (state == IDLE) && start;
  assign last_row       = (rows_written == rows_q - 1'b1);
  assign busy           = (state == RUN);
  assign done           = (state == FIN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (num_rows == '0) ? FIN : RUN;
      RUN:     if (fire && last_row) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_q       <= '0;
      rows_q       <= '0;
      rows_written <= '0;
      overflow     <= 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
        accept_cnt[j] <= '0;
        wr_ptr[j]     <= '0;
        rd_ptr[j]     <= '0;
        count[j]      <= '0;
        for (int unsigned k = 0; k < DEPTH; k++) mem[j][k] <= '0;
      end
    end else begin
      state <= state_nx;
      if (launch) begin
        base_q       <= base_addr;
        rows_q       <= num_rows;
        rows_written <= '0;
        overflow     <= 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
          accept_cnt[j] <= '0;
          wr_ptr[j]     <= '0;
          rd_ptr[j]     <= '0;
          count[j]      <= '0;
        end
      end else begin
        if (fire)    rows_written <= rows_written + 1'b1;
        if (ovf_set) overflow     <= 1'b1;
        for (int unsigned j = 0; j < N; j++) begin
          if (push[j]) begin
            mem[j][wr_ptr[j]] <= vpu_data_in[16*j +: 16];
            wr_ptr[j]         <= wr_ptr[j] + 1'b1;
            accept_cnt[j]     <= accept_cnt[j] + 1'b1;
          end
          if (fire) rd_ptr[j] <= rd_ptr[j] + 1'b1;
          count[j] <= count[j] + {{PW{1'b0}}, push[j]} - {{PW{1'b0}}, fire};
        end
      end
    end
  end
endmodule

// File: tb/tb_vpu_writeback.sv
// Scenario bench for vpu_writeback: expected UB rows are queued as stimulus is
// driven and compared by a write monitor; per-cycle control checks are inline.
module tb_vpu_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr, num_rows;
  logic [31:0] vpu_data_in;
  logic [1:0]  vpu_valid_in;
  logic        busy, done, overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } row_t;
  row_t sb[$];

  vpu_writeback_if #(.N(2), .ADDR_W(16)) ub ();

  vpu_writeback #(.N(2), .DEPTH(4), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .vpu_data_in(vpu_data_in), .vpu_valid_in(vpu_valid_in),
    .ub(ub.master), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    row_t e;
    if (rst_n && ub.ub_wr_valid && ub.ub_wr_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", ub.ub_wr_addr, ub.ub_wr_data);
      end else begin
        e = sb.pop_front();
        if (ub.ub_wr_addr !== e.addr || ub.ub_wr_data !== e.data) begin
          errors++;
          $display("FAIL row_write: got addr=%h data=%h, required addr=%h data=%h",
                   ub.ub_wr_addr, ub.ub_wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v0, input logic [15:0] d0, input logic v1, input logic [15:0] d1);
    vpu_valid_in = {v1, v0};
    vpu_data_in  = {d1, d0};
  endtask

  task automatic push_row(input logic [15:0] a, input logic [15:0] l0, input logic [15:0] l1);
    row_t r;
    r.addr = a;
    r.data = {l1, l0};
    sb.push_back(r);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after the start edge.
  task automatic start_job(input logic [15:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_rows = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ub.ub_wr_valid, ub.ub_wr_addr, ub.ub_wr_data, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b addr=%h data=%h busy=%b done=%b ovf=%b, required all 0",
               ub.ub_wr_valid, ub.ub_wr_addr, ub.ub_wr_data, busy, done, overflow);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ready_cycle: first cycle in which the UB accepts rows.
  task automatic test_staggered(input int ready_cycle);
    int last;
    last = (ready_cycle > 2) ? ready_cycle + 2 : 4;
    push_row(16'h0010, 16'd1, 16'd11);
    push_row(16'h0011, 16'd2, 16'd12);
    push_row(16'h0012, 16'd3, 16'd13);
    start_job(16'h0010, 16'd3);
    for (int c = 0; c <= last + 2; c++) begin
      drive(c <= 2, 16'(c + 1), (c >= 1 && c <= 3), 16'(10 + c));
      ub.ub_wr_ready = (c >= ready_cycle);
      @(negedge clk);
      checks++;
      if (ub.ub_wr_valid !== (c >= 2 && c <= last) || done !== (c == last + 1) || busy !== (c <= last)) begin
        errors++;
        $display("FAIL stag_ctrl c=%0d: got valid=%b done=%b busy=%b, required %b %b %b", c,
                 ub.ub_wr_valid, done, busy, (c >= 2 && c <= last), (c == last + 1), (c <= last));
      end
      if (c >= 2 && c < ready_cycle) begin
        checks++;
        if (ub.ub_wr_addr !== 16'h0010 || ub.ub_wr_data !== {16'd11, 16'd1}) begin
          errors++;
          $display("FAIL hold_stable c=%0d: got addr=%h data=%h, required 0010 000b0001", c, ub.ub_wr_addr, ub.ub_wr_data);
        end
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0);
    checks++;
    if (sb.size() != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL stag_end: got pending=%0d ovf=%b, required 0 0", sb.size(), overflow);
    end
  endtask

  task automatic test_overflow();
    ub.ub_wr_ready = 1'b0;
    start_job(16'h0000, 16'd8);
    for (int c = 0; c <= 5; c++) begin
      drive(c < 5, 16'(100 + c), 0, 0);
      @(negedge clk);
      checks++;
      if (overflow !== (c == 5) || ub.ub_wr_valid !== 1'b0) begin
        errors++;
        $display("FAIL ovf_flag c=%0d: got ovf=%b valid=%b, required %b 0", c, overflow, ub.ub_wr_valid, (c == 5));
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset: got ovf=%b busy=%b, required 0 0", overflow, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    start_job(16'h0000, 16'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_rows_fin: got done=%b busy=%b ovf=%b, required 1 0 0", done, busy, overflow);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_rows_pulse: got done=%b, required 0", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_idle_and_excess();
    ub.ub_wr_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1, 16'h7777, 1, 16'h7777);
      @(negedge clk);
      checks++;
      if (ub.ub_wr_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid c=%0d: got valid=%b busy=%b, required 0 0", c, ub.ub_wr_valid, busy);
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0);
    push_row(16'h0040, 16'd21, 16'd31);
    push_row(16'h0041, 16'd22, 16'd32);
    start_job(16'h0040, 16'd2);
    for (int c = 0; c <= 5; c++) begin
      drive(c < 4, 16'(21 + c), c < 2, 16'(31 + c));
      @(negedge clk);
      checks++;
      if (done !== (c == 3) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL excess c=%0d: got done=%b ovf=%b, required %b 0", c, done, overflow, (c == 3));
      end
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL excess_rows: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    ub.ub_wr_ready = 1'b1;
    push_row(16'hFFFF, 16'd5, 16'd7);
    push_row(16'h0000, 16'd6, 16'd8);
    start_job(16'hFFFF, 16'd2);
    for (int c = 0; c <= 6; c++) begin
      drive(c < 2, 16'(5 + c), (c == 2 || c == 3), 16'(5 + c));
      start = (c == 1);
      base_addr = 16'h1234;
      num_rows = 16'd9;
      @(negedge clk);
      checks++;
      if (done !== (c == 5) || busy !== (c <= 4)) begin
        errors++;
        $display("FAIL wrap_ctrl c=%0d: got done=%b busy=%b, required %b %b", c, done, busy, (c == 5), (c <= 4));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    drive(0, 0, 0, 0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_rows: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    ub.ub_wr_ready = 1'b1;
    push_row(16'h0010, 16'd1, 16'd11);
    push_row(16'h0011, 16'd2, 16'd12);
    push_row(16'h0012, 16'd3, 16'd13);
    start_job(16'h0010, 16'd3);
    for (int c = 0; c <= 2; c++) begin
      drive(1, 16'(c + 1), c >= 1, 16'(10 + c));
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 2) begin
      errors++;
      $display("FAIL mid_first_row: got pending=%0d, required 2", sb.size());
    end
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    checks++;
    if ({ub.ub_wr_valid, ub.ub_wr_addr, ub.ub_wr_data, busy, done, overflow} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b addr=%h data=%h busy=%b done=%b ovf=%b, required all 0",
               ub.ub_wr_valid, ub.ub_wr_addr, ub.ub_wr_data, busy, done, overflow);
    end
    sb.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_done c=%0d: got done=%b, required 0", c, done);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_staggered(0);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_rows = '0;
    vpu_data_in = '0;
    vpu_valid_in = '0;
    ub.ub_wr_ready = 1'b0;
    #2 rst_n = 1'b0;
    test_reset();
    test_staggered(0);
    test_staggered(6);
    test_overflow();
    test_idle_and_excess();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
